uart_rx_ctrl_param: RTL and testbench
=====================================

# uart_rx_ctrl_param

Parametrised UART receive controller. It sequences the start/data/parity/stop phases of one frame and owns the oversampling edge and bit counters. It drives the sampler, deserializer and start/parity/stop checkers, adds configurable data width, odd/even parity, 1 or 2 stop bits, break detection and explicit error pulses, and sits between the RX pin synchronizer and the RX datapath.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- PRESCALE_W, 6, width of oversampling ratio input and edge counter
- clk  in  1  receive clock (oversampled)
- rst  in  1  asynchronous, active-low reset
- rx_in  in  1  synchronized serial line
- prescale  in  PRESCALE_W  clocks per bit; legal even values ≥4
- par_en  in  1  parity bit present
- par_typ  in  1  0 = even, 1 = odd; forwarded to parity checker
- two_stop  in  1  0 = one stop bit, 1 = two
- sampled_bit  in  1  majority-voted bit from sampler; valid at bit end
- start_check_err, par_check_err, stop_check_err  in  1  checker results; valid the cycle after their enable
- enable, data_sample_en, deser_en, start_check_en, par_check_en, stop_check_en  out  1  datapath strobes
- par_typ_q  out  1  latched parity type
- edge_cnt  out  PRESCALE_W  position within current bit
- bit_cnt  out  clog2(DATA_WIDTH+4)  bit index in frame; start = 0
- data_valid, parity_err, framing_err, break_det  out  1  one-cycle result pulses

## Operation
- States: IDLE, START, DATA, PARITY, STOP, ERR_CHECK, DATA_VALID.
- Transition with `rx_in=0` in IDLE goes to START. In that same cycle, drive `enable`, `data_sample_en` and `start_check_en` (Mealy), and latch `prescale`, `par_en`, `par_typ` and `two_stop`. Mid-frame config changes are ignored.
- Counters:
  - `edge_cnt` increments each cycle `enable` is high and wraps at `prescale_q-1`.
  - `bit_cnt` increments on that wrap.
  - Both counters are held at 0 in IDLE, ERR_CHECK and DATA_VALID.
- Bit end is `edge_cnt==prescale_q-1`, abbreviated BE below.
- START, on BE with `bit_cnt==0`:
  - Pulse `start_check_en`.
  - `start_check_err=1` goes to IDLE silently, with no result pulses.
  - Otherwise go to DATA.
- DATA:
  - `deser_en=1` except at BE of the last data bit (`bit_cnt==DATA_WIDTH`).
  - At that BE, go to PARITY if `par_en_q`, else STOP.
- PARITY:
  - At BE with `bit_cnt==DATA_WIDTH+1`, pulse `par_check_en` and go to STOP.
- STOP:
  - `stop_check_en` pulses at BE of each stop bit.
  - The last stop bit index is DATA_WIDTH+1+par_en_q+two_stop_q. On its BE, go to ERR_CHECK.
  - Any stop error within the frame is sticky until ERR_CHECK.
- Break tracking: `sampled_bit` is OR-accumulated at every BE from the first data bit through the last stop bit.
- ERR_CHECK, one cycle, `data_sample_en=1`:
  - Accumulator 0 → `break_det=1`; `framing_err`, `parity_err` and `data_valid` are suppressed; go to IDLE.
  - Else any stop error → `framing_err=1`; parity error → `parity_err=1`; both may pulse together; go to IDLE.
  - Else go to DATA_VALID.
- DATA_VALID: `data_valid=1` for one cycle, then go to IDLE.
- Undefined state encodings go to IDLE.

## Timing
- Reset, asynchronous: state IDLE, counters 0, latched config 0, accumulators cleared, every output 0.
- Reset deasserted mid-frame restarts in IDLE; the partial frame is discarded with no pulses.
- The frame spans F = prescale·(2+DATA_WIDTH+par_en+two_stop) cycles, counted from the detection cycle.
- `data_valid` and the error pulses occur 2 cycles and 1 cycle after the final BE respectively.
- Back-to-back frames: a falling `rx_in` is first accepted in the cycle after DATA_VALID (or after ERR_CHECK on error).
- All strobes are combinational from state and counters; no output is registered.

## Structure
- Package `uart_rx_pkg`:
  - state encodings (3-bit)
  - `BIT_CNT_W` function of DATA_WIDTH
  - default prescale constant
- Sub-module `uart_rx_bit_timer`: edge and bit counters with wrap and BE strobe. The FSM, config latches and error/break accumulation stay in the top.

## Test plan
- DATA_WIDTH=8, prescale=8, no parity, 1 stop, byte 0xA5 → `data_valid` 2 cycles after cycle 80. No error pulses. `deser_en` is high for 63 cycles.
- DATA_WIDTH=7, prescale=16, odd parity, 2 stop, `par_check_err=1` → `parity_err` pulse at cycle 177 (F=176). No `data_valid`.
- Glitch: `rx_in` low for 2 cycles, `start_check_err=1` at BE → back in IDLE at cycle 8. No pulses. A new frame is accepted the next cycle.
- Line held low 10 bits (8N1) → `break_det` only. `framing_err=0`.
- Second stop bit low with `two_stop=1`; `two_stop` toggled mid-frame → `framing_err`. Frame length uses the latched value.
- `rst` asserted during DATA → all outputs 0 immediately. Clean reception of the next frame.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   rx_state_t        3-bit FSM state encoding
//   DEFAULT_PRESCALE  typical oversampling ratio (clocks per bit)
//   bit_cnt_w()       width of the in-frame bit index for a given data width
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_ERR_CHECK  = 3'd5,
    ST_DATA_VALID = 3'd6
  } rx_state_t;

  localparam int DEFAULT_PRESCALE = 16;

  // Bit index runs 0 (start) .. DATA_WIDTH+3 (second stop with parity).
  function automatic int bit_cnt_w(input int data_width);
    return $clog2(data_width + 4);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_timer
// Oversampling edge counter and in-frame bit counter.
//   clk, rst_n      clock, asynchronous active-low reset
//   i_enable        advance the edge counter this cycle
//   i_clear         force both counters to 0 (wins over i_enable)
//   i_prescale      clocks per bit
//   o_edge_cnt      position within the current bit
//   o_bit_cnt       bit index within the frame (start = 0)
//   o_bit_end       last edge of the current bit while enabled
// -----------------------------------------------------------------------------
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic                  o_bit_end
);

  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  w_last_edge;

  assign w_last_edge = (r_edge_cnt == (i_prescale - P_ONE));
  assign o_bit_end   = i_enable & w_last_edge;
  assign o_edge_cnt  = r_edge_cnt;
  assign o_bit_cnt   = r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clear) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_enable) begin
      if (w_last_edge) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + B_ONE;
      end else begin
        r_edge_cnt <= r_edge_cnt + P_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_param.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_param
// UART receive frame controller: sequences start/data/parity/stop, owns the
// bit timer, latches frame configuration and accumulates error/break status.
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_rx_in                         synchronized serial line
//   i_prescale, i_par_en, i_par_typ, i_two_stop
//                                   frame config, latched at start detection
//   i_sampled_bit                   majority-voted bit, valid at bit end
//   i_start/par/stop_check_err      checker results
//   o_enable .. o_stop_check_en     datapath strobes (combinational)
//   o_par_typ_q                     latched parity type
//   o_edge_cnt, o_bit_cnt           timer position
//   o_data_valid, o_parity_err, o_framing_err, o_break_det
//                                   one-cycle result pulses
// -----------------------------------------------------------------------------
module uart_rx_ctrl_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_rx_in,
  input  logic [PRESCALE_W-1:0]               i_prescale,
  input  logic                                i_par_en,
  input  logic                                i_par_typ,
  input  logic                                i_two_stop,
  input  logic                                i_sampled_bit,
  input  logic                                i_start_check_err,
  input  logic                                i_par_check_err,
  input  logic                                i_stop_check_err,
  output logic                                o_enable,
  output logic                                o_data_sample_en,
  output logic                                o_deser_en,
  output logic                                o_start_check_en,
  output logic                                o_par_check_en,
  output logic                                o_stop_check_en,
  output logic                                o_par_typ_q,
  output logic [PRESCALE_W-1:0]               o_edge_cnt,
  output logic [bit_cnt_w(DATA_WIDTH)-1:0]    o_bit_cnt,
  output logic                                o_data_valid,
  output logic                                o_parity_err,
  output logic                                o_framing_err,
  output logic                                o_break_det
);

  localparam int BIT_CNT_W = bit_cnt_w(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] PARITY_IDX    = BIT_CNT_W'(DATA_WIDTH + 1);

  rx_state_t             r_state;
  logic [PRESCALE_W-1:0] r_prescale_q;
  logic                  r_par_en_q, r_par_typ_q, r_two_stop_q;
  logic                  r_brk_acc, r_stop_err, r_par_err;
  logic                  r_stop_pend, r_par_pend;

  logic                  w_start_det, w_active, w_be, w_frame_end, w_cnt_clr;
  logic                  w_stop_err_now, w_par_err_now, w_stop_err_any, w_par_err_any;
  logic [PRESCALE_W-1:0] w_prescale_eff, w_edge_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_cnt, w_last_stop_idx;

  // Detection is gated by rst_n so nothing strobes while held in reset.
  assign w_start_det = rst_n & (r_state == ST_IDLE) & ~i_rx_in;
  assign w_active    = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  // In IDLE the config is not latched yet, so time the detection cycle live.
  assign w_prescale_eff  = (r_state == ST_IDLE) ? i_prescale : r_prescale_q;
  assign w_last_stop_idx = PARITY_IDX + BIT_CNT_W'(r_par_en_q) + BIT_CNT_W'(r_two_stop_q);

  // Ending a frame must also clear the counters, otherwise the bit counter
  // would carry its wrap increment into an immediately following frame.
  assign w_frame_end = w_be & (((r_state == ST_START) & i_start_check_err) |
                               ((r_state == ST_STOP) & (w_bit_cnt == w_last_stop_idx)));
  assign w_cnt_clr   = w_frame_end | ~o_enable;

  uart_rx_bit_timer #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (o_enable),
    .i_clear    (w_cnt_clr),
    .i_prescale (w_prescale_eff),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_end  (w_be)
  );

  // Checker results arrive one cycle after their enable.
  assign w_stop_err_now = r_stop_pend & i_stop_check_err;
  assign w_par_err_now  = r_par_pend & i_par_check_err;
  assign w_stop_err_any = r_stop_err | w_stop_err_now;
  assign w_par_err_any  = r_par_err | w_par_err_now;

  assign o_enable         = w_active | w_start_det;
  assign o_data_sample_en = o_enable | (r_state == ST_ERR_CHECK);
  assign o_start_check_en = w_start_det |
                            ((r_state == ST_START) & w_be & (w_bit_cnt == '0));
  assign o_deser_en       = (r_state == ST_DATA) & ~(w_be & (w_bit_cnt == LAST_DATA_IDX));
  assign o_par_check_en   = (r_state == ST_PARITY) & w_be & (w_bit_cnt == PARITY_IDX);
  assign o_stop_check_en  = (r_state == ST_STOP) & w_be;
  assign o_par_typ_q      = r_par_typ_q;
  assign o_edge_cnt       = w_edge_cnt;
  assign o_bit_cnt        = w_bit_cnt;

  // A line that stayed low for the whole frame is a break; it masks errors.
  assign o_break_det   = (r_state == ST_ERR_CHECK) & ~r_brk_acc;
  assign o_framing_err = (r_state == ST_ERR_CHECK) & r_brk_acc & w_stop_err_any;
  assign o_parity_err  = (r_state == ST_ERR_CHECK) & r_brk_acc & w_par_err_any;
  assign o_data_valid  = (r_state == ST_DATA_VALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prescale_q <= '0;
      r_par_en_q   <= 1'b0;
      r_par_typ_q  <= 1'b0;
      r_two_stop_q <= 1'b0;
      r_brk_acc    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_par_pend   <= 1'b0;
    end else begin
      r_stop_pend <= o_stop_check_en;
      r_par_pend  <= o_par_check_en;
      if (w_stop_err_now) r_stop_err <= 1'b1;
      if (w_par_err_now)  r_par_err  <= 1'b1;
      if (w_be && (r_state inside {ST_DATA, ST_PARITY, ST_STOP}))
        r_brk_acc <= r_brk_acc | i_sampled_bit;

      case (r_state)
        ST_IDLE: begin
          if (w_start_det) begin
            r_state      <= ST_START;
            r_prescale_q <= i_prescale;
            r_par_en_q   <= i_par_en;
            r_par_typ_q  <= i_par_typ;
            r_two_stop_q <= i_two_stop;
            r_brk_acc    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_par_err    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_be && (w_bit_cnt == '0))
            r_state <= i_start_check_err ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_be && (w_bit_cnt == LAST_DATA_IDX))
            r_state <= r_par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (w_be && (w_bit_cnt == PARITY_IDX))
            r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_be && (w_bit_cnt == w_last_stop_idx))
            r_state <= ST_ERR_CHECK;
        end
        ST_ERR_CHECK: begin
          if (!r_brk_acc || w_stop_err_any || w_par_err_any)
            r_state <= ST_IDLE;
          else
            r_state <= ST_DATA_VALID;
        end
        ST_DATA_VALID: r_state <= ST_IDLE;
        default:       r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl_param
// Drives whole frames cycle by cycle and compares the controller's strobes,
// counters and result pulses against frame arithmetic (frame length, bit
// positions, expected outcome). Two instances: DATA_WIDTH 8 and 7.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl_param;

  localparam int S_EN = 0, S_DSE = 1, S_DESER = 2, S_STARTC = 3, S_PARC = 4;
  localparam int S_STOPC = 5, S_DV = 6, S_PE = 7, S_FE = 8, S_BD = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, par_typ, two_stop, sampled_bit;
  logic       start_check_err, par_check_err, stop_check_err;

  wire [9:0]  d8_str, d7_str;
  wire [5:0]  d8_edge, d7_edge;
  wire [3:0]  d8_bit, d7_bit;
  wire        d8_ptyp, d7_ptyp;

  int sel = 8;
  int errors = 0;
  int checks = 0;

  wire [9:0] m_str  = (sel == 7) ? d7_str  : d8_str;
  wire [5:0] m_edge = (sel == 7) ? d7_edge : d8_edge;
  wire [3:0] m_bit  = (sel == 7) ? d7_bit  : d8_bit;
  wire       m_ptyp = (sel == 7) ? d7_ptyp : d8_ptyp;

  always #5 clk = ~clk;

  uart_rx_ctrl_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_rx_in(rx_in), .i_prescale(prescale),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_two_stop(two_stop),
    .i_sampled_bit(sampled_bit), .i_start_check_err(start_check_err),
    .i_par_check_err(par_check_err), .i_stop_check_err(stop_check_err),
    .o_enable(d8_str[S_EN]), .o_data_sample_en(d8_str[S_DSE]),
    .o_deser_en(d8_str[S_DESER]), .o_start_check_en(d8_str[S_STARTC]),
    .o_par_check_en(d8_str[S_PARC]), .o_stop_check_en(d8_str[S_STOPC]),
    .o_par_typ_q(d8_ptyp), .o_edge_cnt(d8_edge), .o_bit_cnt(d8_bit),
    .o_data_valid(d8_str[S_DV]), .o_parity_err(d8_str[S_PE]),
    .o_framing_err(d8_str[S_FE]), .o_break_det(d8_str[S_BD])
  );

  uart_rx_ctrl_param #(.DATA_WIDTH(7), .PRESCALE_W(6)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .i_rx_in(rx_in), .i_prescale(prescale),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_two_stop(two_stop),
    .i_sampled_bit(sampled_bit), .i_start_check_err(start_check_err),
    .i_par_check_err(par_check_err), .i_stop_check_err(stop_check_err),
    .o_enable(d7_str[S_EN]), .o_data_sample_en(d7_str[S_DSE]),
    .o_deser_en(d7_str[S_DESER]), .o_start_check_en(d7_str[S_STARTC]),
    .o_par_check_en(d7_str[S_PARC]), .o_stop_check_en(d7_str[S_STOPC]),
    .o_par_typ_q(d7_ptyp), .o_edge_cnt(d7_edge), .o_bit_cnt(d7_bit),
    .o_data_valid(d7_str[S_DV]), .o_parity_err(d7_str[S_PE]),
    .o_framing_err(d7_str[S_FE]), .o_break_det(d7_str[S_BD])
  );

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_in = 1'b1; sampled_bit = 1'b1;
      start_check_err = 1'b0; par_check_err = 1'b0; stop_check_err = 1'b0;
    end
  endtask

  // One frame, detection cycle = c 1. Config is scrambled at c 2 to prove
  // it was latched. abort_at > 0 stops early and skips outcome checks.
  task automatic run_frame(input string name, input int dw, input int p,
                           input bit pe, input bit pt, input bit ts,
                           input logic [8:0] data, input bit brk,
                           input bit perr, input bit serr, input int abort_at);
    bit bits[$];
    int ones = 0, nbits, f, last, cnt_bad = 0;
    int n_en = 0, n_dse = 0, n_deser = 0, n_startc = 0, n_parc = 0, n_stopc = 0;
    int n_dv = 0, n_pe = 0, n_fe = 0, n_bd = 0;
    int dv_at = 0, pe_at = 0, fe_at = 0, bd_at = 0;
    int exp_dv, exp_pe, exp_fe, exp_bd;
    bit ptyp_bad = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    if (brk) foreach (bits[i]) bits[i] = 1'b0;
    nbits  = bits.size();
    f      = p * nbits;
    exp_bd = int'(brk);
    exp_fe = int'(!brk && serr);
    exp_pe = int'(!brk && pe && perr);
    exp_dv = int'(!brk && !serr && !(pe && perr));
    last   = (abort_at > 0) ? abort_at : ((exp_dv == 1) ? f + 2 : f + 1);

    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      rx_in = (c <= f) ? bits[(c - 1) / p] : 1'b1;
      sampled_bit = rx_in;
      if (c == 1) begin
        prescale = 6'(p); par_en = pe; par_typ = pt; two_stop = ts;
      end else if (c == 2) begin
        prescale = 6'(2 * $urandom_range(2, 8));
        par_en = ~pe; par_typ = ~pt; two_stop = ~ts;
      end
      start_check_err = 1'b0;
      par_check_err   = perr;
      stop_check_err  = serr && (c > p * (nbits - 1) + 1) && (c <= f + 1);
      @(negedge clk);
      if (c <= f && (int'(m_edge) != (c - 1) % p || int'(m_bit) != (c - 1) / p))
        cnt_bad++;
      n_en     += int'(m_str[S_EN]);
      n_dse    += int'(m_str[S_DSE]);
      n_deser  += int'(m_str[S_DESER]);
      n_startc += int'(m_str[S_STARTC]);
      n_parc   += int'(m_str[S_PARC]);
      n_stopc  += int'(m_str[S_STOPC]);
      if (m_str[S_DV]) begin n_dv++; dv_at = c; end
      if (m_str[S_PE]) begin n_pe++; pe_at = c; end
      if (m_str[S_FE]) begin n_fe++; fe_at = c; end
      if (m_str[S_BD]) begin n_bd++; bd_at = c; end
      if (c == f && m_ptyp !== pt) ptyp_bad = 1'b1;
    end

    checks++;
    if (cnt_bad != 0) begin
      errors++; $display("FAIL %s counters: %0d cycles with wrong edge/bit, want 0", name, cnt_bad);
    end
    if (abort_at > 0) return;
    $display("frame %s: dw=%0d p=%0d pe=%0d ts=%0d F=%0d dv=%0d@%0d pe=%0d@%0d fe=%0d@%0d bd=%0d@%0d",
             name, dw, p, pe, ts, f, n_dv, dv_at, n_pe, pe_at, n_fe, fe_at, n_bd, bd_at);
    checks++;
    if (n_en != f) begin
      errors++; $display("FAIL %s enable: got %0d cycles, want %0d", name, n_en, f);
    end
    checks++;
    if (n_dse != f + 1) begin
      errors++; $display("FAIL %s data_sample_en: got %0d cycles, want %0d", name, n_dse, f + 1);
    end
    checks++;
    if (n_deser != p * dw - 1) begin
      errors++; $display("FAIL %s deser_en: got %0d cycles, want %0d", name, n_deser, p * dw - 1);
    end
    checks++;
    if (n_startc != 2) begin
      errors++; $display("FAIL %s start_check_en: got %0d, want 2", name, n_startc);
    end
    checks++;
    if (n_parc != int'(pe)) begin
      errors++; $display("FAIL %s par_check_en: got %0d, want %0d", name, n_parc, int'(pe));
    end
    checks++;
    if (n_stopc != 1 + int'(ts)) begin
      errors++; $display("FAIL %s stop_check_en: got %0d, want %0d", name, n_stopc, 1 + int'(ts));
    end
    checks++;
    if (n_dv != exp_dv || (exp_dv == 1 && dv_at != f + 2)) begin
      errors++; $display("FAIL %s data_valid: got n=%0d at %0d, want n=%0d at %0d", name, n_dv, dv_at, exp_dv, f + 2);
    end
    checks++;
    if (n_pe != exp_pe || (exp_pe == 1 && pe_at != f + 1)) begin
      errors++; $display("FAIL %s parity_err: got n=%0d at %0d, want n=%0d at %0d", name, n_pe, pe_at, exp_pe, f + 1);
    end
    checks++;
    if (n_fe != exp_fe || (exp_fe == 1 && fe_at != f + 1)) begin
      errors++; $display("FAIL %s framing_err: got n=%0d at %0d, want n=%0d at %0d", name, n_fe, fe_at, exp_fe, f + 1);
    end
    checks++;
    if (n_bd != exp_bd || (exp_bd == 1 && bd_at != f + 1)) begin
      errors++; $display("FAIL %s break_det: got n=%0d at %0d, want n=%0d at %0d", name, n_bd, bd_at, exp_bd, f + 1);
    end
    checks++;
    if (ptyp_bad) begin
      errors++; $display("FAIL %s par_typ_q: got %0b, want %0b", name, m_ptyp, pt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_in = 1'b0; sampled_bit = 1'b0; prescale = 6'd8;
    par_en = 1'b1; par_typ = 1'b1; two_stop = 1'b1;
    start_check_err = 1'b0; par_check_err = 1'b0; stop_check_err = 1'b0;
    #2;
    checks++;
    if (d8_str !== 10'd0 || d7_str !== 10'd0) begin
      errors++; $display("FAIL reset_strobes: got %b/%b, want 0", d8_str, d7_str);
    end
    checks++;
    if (d8_edge !== 6'd0 || d8_bit !== 4'd0 || d8_ptyp !== 1'b0 ||
        d7_edge !== 6'd0 || d7_bit !== 4'd0 || d7_ptyp !== 1'b0) begin
      errors++; $display("FAIL reset_state: got edge=%0d bit=%0d ptyp=%0b, want 0", d8_edge, d8_bit, d8_ptyp);
    end
    repeat (3) @(posedge clk);
    #1; rx_in = 1'b1; sampled_bit = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d8_str !== 10'd0 || d7_str !== 10'd0 || d8_edge !== 6'd0) begin
      errors++; $display("FAIL reset_idle: got %b/%b edge=%0d, want 0", d8_str, d7_str, d8_edge);
    end
    $display("reset: checked");
  endtask

  task automatic test_basic();
    run_frame("basic_8N1_A5", 8, 8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_glitch();
    int n_en = 0, n_startc = 0, n_res = 0;
    logic [5:0] edge_be = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      rx_in = (c <= 2) ? 1'b0 : 1'b1;
      sampled_bit = rx_in;
      if (c == 1) prescale = 6'd8;
      start_check_err = 1'b1;
      @(negedge clk);
      n_en     += int'(m_str[S_EN]);
      n_startc += int'(m_str[S_STARTC]);
      n_res    += int'(m_str[S_DV]) + int'(m_str[S_PE]) + int'(m_str[S_FE]) + int'(m_str[S_BD]);
      if (c == 8) edge_be = m_edge;
    end
    $display("glitch: enable=%0d start_check=%0d results=%0d", n_en, n_startc, n_res);
    checks++;
    if (n_en != 8 || n_startc != 2) begin
      errors++; $display("FAIL glitch_strobes: got enable=%0d start_check=%0d, want 8 and 2", n_en, n_startc);
    end
    checks++;
    if (n_res != 0 || edge_be != 6'd7) begin
      errors++; $display("FAIL glitch_result: got pulses=%0d edge=%0d, want 0 and 7", n_res, edge_be);
    end
    // Next frame starts in the very next cycle.
    run_frame("after_glitch", 8, 8, 1'b1, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_break();
    run_frame("break_8N1", 8, 8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_two_stop();
    run_frame("stop2_err", 8, 8, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_parity();
    sel = 7;
    run_frame("par_odd_7O2", 7, 16, 1'b1, 1'b1, 1'b1, 9'h04B, 1'b0, 1'b1, 1'b0, 0);
    idle_gap(300);
    sel = 8;
  endtask

  task automatic test_rst_mid();
    run_frame("rst_pre", 8, 8, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 40);
    @(posedge clk); #1;
    rx_in = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if (d8_str !== 10'd0 || d8_edge !== 6'd0 || d8_bit !== 4'd0 || d8_ptyp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_now: got str=%b edge=%0d bit=%0d ptyp=%0b, want 0", d8_str, d8_edge, d8_bit, d8_ptyp);
    end
    @(negedge clk);
    checks++;
    if (d8_str !== 10'd0 || d7_str !== 10'd0) begin
      errors++; $display("FAIL rst_mid_hold: got %b/%b, want 0", d8_str, d7_str);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rx_in = 1'b1; sampled_bit = 1'b1;
    @(negedge clk);
    checks++;
    if (d8_str !== 10'd0) begin
      errors++; $display("FAIL rst_mid_idle: got %b, want 0", d8_str);
    end
    run_frame("after_rst", 8, 8, 1'b0, 1'b0, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 13; k++) begin
      int p, dw;
      bit pe, pt, ts, brk, perr, serr;
      if (k == 8) begin idle_gap(300); sel = 7; end
      dw   = (sel == 7) ? 7 : 8;
      p    = 2 * $urandom_range(2, 8);
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      ts   = 1'($urandom_range(0, 1));
      brk  = ($urandom_range(0, 7) == 0);
      perr = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 4) == 0);
      run_frame($sformatf("b2b_%0d", k), dw, p, pe, pt, ts, 9'($urandom),
                brk, perr, serr, 0);
    end
    idle_gap(300);
    sel = 8;
  endtask

  initial begin
    test_reset();
    idle_gap(4);
    test_basic();
    idle_gap(5);
    test_glitch();
    idle_gap(300);
    test_break();
    idle_gap(300);
    test_two_stop();
    idle_gap(300);
    test_parity();
    test_rst_mid();
    idle_gap(300);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
